// File: rtl/gamma_lut_ctrl.sv
// Double-buffered 256x8 gamma LUT for a {R,G,B} pixel stream; banks swap only at a frame start.
// Define GAMMA_READBACK_EN to add a host readback port for the shadow table.
module gamma_lut_ctrl #(
  parameter logic VSYNC_POL  = 1'b1,
  parameter int   INIT_GAMMA = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pre_vsync,
  input  logic        pre_hsync,
  input  logic        pre_de,
  input  logic [23:0] pre_data,
  output logic        post_vsync,
  output logic        post_hsync,
  output logic        post_de,
  output logic [23:0] post_data,
  input  logic        cfg_wr_valid,
  output logic        cfg_wr_ready,
  input  logic [7:0]  cfg_wr_addr,
  input  logic [7:0]  cfg_wr_data,
  input  logic        cfg_commit,
  output logic        busy,
  output logic        active_bank
`ifdef GAMMA_READBACK_EN
  ,
  input  logic        cfg_rd_valid,
  input  logic [7:0]  cfg_rd_addr,
  output logic [7:0]  cfg_rd_data,
  output logic        cfg_rd_dvalid
`endif
);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;
  localparam logic [1:0] ST_COPY = 2'd3;

  logic [1:0]  state_reg;
  logic [7:0]  cnt_reg;
  logic        active_bank_reg;

  logic [7:0]  mem0 [0:255];
  logic [7:0]  mem1 [0:255];

  logic        vs1_reg, hs1_reg, de1_reg, use_lut1_reg;
  logic [23:0] data1_reg;
  logic [23:0] lut_word;

  logic        wr_fire;
  logic        frame_start;
  logic [7:0]  init_val;
  logic [7:0]  copy_val;
  logic        we0, we1;
  logic [7:0]  waddr, wdata;

  assign wr_fire     = cfg_wr_valid && (state_reg == ST_IDLE);
  // Edge into the sync level: live input against its stage-1 registered copy.
  assign frame_start = (pre_vsync == VSYNC_POL) && (vs1_reg != VSYNC_POL);
  assign init_val    = (INIT_GAMMA != 0) ? 8'((16'(cnt_reg) * 16'(cnt_reg)) >> 8) : cnt_reg;
  assign copy_val    = active_bank_reg ? mem1[cnt_reg] : mem0[cnt_reg];

  always_comb begin
    we0   = 1'b0;
    we1   = 1'b0;
    waddr = cnt_reg;
    wdata = init_val;
    case (state_reg)
      ST_INIT: begin
        we0 = 1'b1;
        we1 = 1'b1;
      end
      ST_IDLE: begin
        if (wr_fire) begin
          waddr = cfg_wr_addr;
          wdata = cfg_wr_data;
          we0   = active_bank_reg;
          we1   = ~active_bank_reg;
        end
      end
      ST_COPY: begin
        wdata = copy_val;
        we0   = active_bank_reg;
        we1   = ~active_bank_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we0) mem0[waddr] <= wdata;
    if (we1) mem1[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_INIT;
      cnt_reg         <= 8'd0;
      active_bank_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT, ST_COPY: begin
          cnt_reg <= cnt_reg + 8'd1;
          if (cnt_reg == 8'd255) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 8'd0;
          end
        end
        ST_IDLE: begin
          if (cfg_commit) state_reg <= ST_PEND;
        end
        ST_PEND: begin
          if (frame_start) begin
            active_bank_reg <= ~active_bank_reg;
            cnt_reg         <= 8'd0;
            state_reg       <= ST_COPY;
          end
        end
        default: state_reg <= ST_INIT;
      endcase
    end
  end

  // Three registered reads of the active bank, one per colour channel.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [7:0] rd_reg;
    always_ff @(posedge clk) begin
      rd_reg <= active_bank_reg ? mem1[pre_data[gi*8 +: 8]] : mem0[pre_data[gi*8 +: 8]];
    end
    assign lut_word[gi*8 +: 8] = rd_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs1_reg      <= 1'b0;
      hs1_reg      <= 1'b0;
      de1_reg      <= 1'b0;
      data1_reg    <= 24'd0;
      use_lut1_reg <= 1'b0;
      post_vsync   <= 1'b0;
      post_hsync   <= 1'b0;
      post_de      <= 1'b0;
      post_data    <= 24'd0;
    end else begin
      vs1_reg      <= pre_vsync;
      hs1_reg      <= pre_hsync;
      de1_reg      <= pre_de;
      data1_reg    <= pre_data;
      use_lut1_reg <= en && (state_reg != ST_INIT);
      post_vsync   <= vs1_reg;
      post_hsync   <= hs1_reg;
      post_de      <= de1_reg;
      post_data    <= use_lut1_reg ? lut_word : data1_reg;
    end
  end

  assign busy         = (state_reg != ST_IDLE);
  assign cfg_wr_ready = (state_reg == ST_IDLE);
  assign active_bank  = active_bank_reg;

`ifdef GAMMA_READBACK_EN
  logic [7:0] rd_data_reg;
  logic       rd_dvalid_reg;

  // Non-blocking read alongside the shadow write returns the pre-write value.
  always_ff @(posedge clk) begin
    rd_data_reg <= active_bank_reg ? mem0[cfg_rd_addr] : mem1[cfg_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_dvalid_reg <= 1'b0;
    else     rd_dvalid_reg <= cfg_rd_valid && (state_reg == ST_IDLE);
  end

  assign cfg_rd_data   = rd_data_reg;
  assign cfg_rd_dvalid = rd_dvalid_reg;
`endif

endmodule
